memorystage1: RTL and testbench

//  Pipeline stage 1: decodes the fetched instruction, computes its effective address and runs the data-bus cycle for LOAD/LOADR/STORE/STORER.

---
 rtl/memorystage1_pkg.sv | 26 ++
 rtl/memorystage1_addrgen.sv | 45 ++++
 rtl/memorystage1.sv | 130 +++++++++++++
 tb/tb_memorystage1.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memorystage1_pkg.sv
// Shared opcode, cycle-width and stage-1 FSM encodings for the memory stage.
package memorystage1_pkg;

    typedef logic [4:0] opcode_t;

    localparam opcode_t OPCODE_NOP    = 5'h00;
    localparam opcode_t OPCODE_LOAD   = 5'h01;
    localparam opcode_t OPCODE_LOADR  = 5'h02;
    localparam opcode_t OPCODE_STORE  = 5'h03;
    localparam opcode_t OPCODE_STORER = 5'h04;
    localparam opcode_t OPCODE_ADD    = 5'h08;

    localparam logic [1:0] CW_BYTE = 2'b00;
    localparam logic [1:0] CW_WORD = 2'b01;
    localparam logic [1:0] CW_LONG = 2'b10;

    localparam logic S1_IDLE = 1'b0;
    localparam logic S1_WAIT = 1'b1;

    localparam logic [31:0] NOP_INSTRUCTION = {OPCODE_NOP, 27'h0};

    function automatic logic [31:0] sext16(input logic [15:0] value);
        return {{16{value[15]}}, value};
    endfunction

endpackage

// File: rtl/memorystage1_addrgen.sv
// Combinational decode of memory opcodes and effective-address generation.
module memorystage1_addrgen
    import memorystage1_pkg::*;
(
    input  logic [4:0]  opcode,
    input  logic [31:0] reg_a_data,
    input  logic [15:0] offset,
    output logic [31:0] address,
    output logic        is_mem,
    output logic        is_store,
    output logic        uses_a,
    output logic        uses_b
);

    always_comb begin
        is_mem   = 1'b0;
        is_store = 1'b0;
        uses_a   = 1'b0;
        uses_b   = 1'b0;
        case (opcode)
            OPCODE_LOAD: begin
                is_mem = 1'b1;
            end
            OPCODE_LOADR: begin
                is_mem = 1'b1;
                uses_a = 1'b1;
            end
            OPCODE_STORE: begin
                is_mem   = 1'b1;
                is_store = 1'b1;
                uses_b   = 1'b1;
            end
            OPCODE_STORER: begin
                is_mem   = 1'b1;
                is_store = 1'b1;
                uses_a   = 1'b1;
                uses_b   = 1'b1;
            end
            default: begin
            end
        endcase
        address = uses_a ? reg_a_data + sext16(offset) : sext16(offset);
    end

endmodule

// File: rtl/memorystage1.sv
// Pipeline stage 1: decode, effective address, data-bus cycle for loads/stores,
// RAW-hazard bubbles against stage 2 and squash on stage-2 jump.
module memorystage1
    import memorystage1_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] inbound_instruction,
    output logic        stall,
    output logic [3:0]  reg_a_index,
    output logic [3:0]  reg_b_index,
    input  logic [31:0] reg_a_data,
    input  logic [31:0] reg_b_data,
    input  logic [3:0]  s2_write_index,
    input  logic        s2_writing,
    input  logic        jump,
    output logic        bus_request,
    output logic        bus_write,
    output logic [31:0] bus_address,
    output logic [1:0]  bus_cycle_width,
    output logic [31:0] bus_data_out,
    input  logic [31:0] bus_data_in,
    input  logic        bus_ack,
    output logic [31:0] outbound_instruction,
    output logic [31:0] data_out,
    output logic        bus_error
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic             state;
    logic [CNT_W-1:0] wait_count;
    logic [31:0]      held_instruction;
    logic             held_store;

    logic [31:0] address;
    logic        is_mem;
    logic        is_store;
    logic        uses_a;
    logic        uses_b;
    logic        hazard;
    logic        timeout;

    assign reg_a_index = inbound_instruction[19:16];
    assign reg_b_index = inbound_instruction[23:20];

    memorystage1_addrgen u_addrgen (
        .opcode     (inbound_instruction[31:27]),
        .reg_a_data (reg_a_data),
        .offset     (inbound_instruction[15:0]),
        .address    (address),
        .is_mem     (is_mem),
        .is_store   (is_store),
        .uses_a     (uses_a),
        .uses_b     (uses_b)
    );

    always_comb begin
        hazard  = s2_writing &&
                  ((uses_a && (s2_write_index == reg_a_index)) ||
                   (uses_b && (s2_write_index == reg_b_index)));
        timeout = (state == S1_WAIT) && !bus_ack &&
                  (wait_count == CNT_W'(TIMEOUT_CYCLES - 1));
        // A timed-out access releases fetch so the dropped instruction is not reissued.
        if (state == S1_IDLE)
            stall = is_mem && !jump;
        else
            stall = !bus_ack && !timeout;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state                <= S1_IDLE;
            wait_count           <= '0;
            held_instruction     <= NOP_INSTRUCTION;
            held_store           <= 1'b0;
            outbound_instruction <= NOP_INSTRUCTION;
            data_out             <= '0;
            bus_request          <= 1'b0;
            bus_write            <= 1'b0;
            bus_address          <= '0;
            bus_cycle_width      <= CW_LONG;
            bus_data_out         <= '0;
            bus_error            <= 1'b0;
        end else begin
            case (state)
                S1_IDLE: begin
                    wait_count <= '0;
                    if (jump) begin
                        outbound_instruction <= NOP_INSTRUCTION;
                    end else if (is_mem) begin
                        outbound_instruction <= NOP_INSTRUCTION;
                        if (!hazard) begin
                            held_instruction <= inbound_instruction;
                            held_store       <= is_store;
                            bus_request      <= 1'b1;
                            bus_write        <= is_store;
                            bus_address      <= address;
                            bus_cycle_width  <= inbound_instruction[26:25];
                            bus_data_out     <= reg_b_data;
                            state            <= S1_WAIT;
                        end
                    end else begin
                        outbound_instruction <= inbound_instruction;
                    end
                end
                default: begin
                    if (bus_ack) begin
                        bus_request          <= 1'b0;
                        outbound_instruction <= held_instruction;
                        if (!held_store)
                            data_out <= bus_data_in;
                        state <= S1_IDLE;
                    end else if (timeout) begin
                        bus_request          <= 1'b0;
                        bus_error            <= 1'b1;
                        outbound_instruction <= NOP_INSTRUCTION;
                        state                <= S1_IDLE;
                    end else begin
                        wait_count           <= wait_count + CNT_W'(1);
                        outbound_instruction <= NOP_INSTRUCTION;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memorystage1.sv
// Self-checking bench for memorystage1: scripted fetch/bus stimulus plus an
// outbound-instruction scoreboard.
module tb_memorystage1;
    import memorystage1_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] inbound_instruction;
    logic        stall;
    logic [3:0]  reg_a_index;
    logic [3:0]  reg_b_index;
    logic [31:0] reg_a_data;
    logic [31:0] reg_b_data;
    logic [3:0]  s2_write_index;
    logic        s2_writing;
    logic        jump;
    logic        bus_request;
    logic        bus_write;
    logic [31:0] bus_address;
    logic [1:0]  bus_cycle_width;
    logic [31:0] bus_data_out;
    logic [31:0] bus_data_in;
    logic        bus_ack;
    logic [31:0] outbound_instruction;
    logic [31:0] data_out;
    logic        bus_error;

    logic [31:0] regs [16];
    logic [31:0] expq [$];
    int total = 0;
    int bad = 0;

    assign reg_a_data = regs[reg_a_index];
    assign reg_b_data = regs[reg_b_index];

    always #5 clock = ~clock;

    memorystage1 #(.TIMEOUT_CYCLES(4)) dut (
        .clock                (clock),
        .reset                (reset),
        .inbound_instruction  (inbound_instruction),
        .stall                (stall),
        .reg_a_index          (reg_a_index),
        .reg_b_index          (reg_b_index),
        .reg_a_data           (reg_a_data),
        .reg_b_data           (reg_b_data),
        .s2_write_index       (s2_write_index),
        .s2_writing           (s2_writing),
        .jump                 (jump),
        .bus_request          (bus_request),
        .bus_write            (bus_write),
        .bus_address          (bus_address),
        .bus_cycle_width      (bus_cycle_width),
        .bus_data_out         (bus_data_out),
        .bus_data_in          (bus_data_in),
        .bus_ack              (bus_ack),
        .outbound_instruction (outbound_instruction),
        .data_out             (data_out),
        .bus_error            (bus_error)
    );

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [1:0] cw,
                                       input logic [3:0] b, input logic [3:0] a,
                                       input logic [15:0] off);
        return {op, cw, 1'b0, b, a, off};
    endfunction

    // Scoreboard: every non-NOP instruction reaching stage 2 must be the next expected one.
    always @(negedge clock) begin
        if (reset === 1'b1 && outbound_instruction !== NOP_INSTRUCTION) begin
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("FAIL outbound_unexpected got=%h expected=none", outbound_instruction);
            end else begin
                logic [31:0] e;
                e = expq.pop_front();
                if (outbound_instruction !== e) begin
                    bad++;
                    $display("FAIL outbound_order got=%h expected=%h", outbound_instruction, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        inbound_instruction = NOP_INSTRUCTION;
        s2_write_index = 4'd0;
        s2_writing = 1'b0;
        jump = 1'b0;
        bus_data_in = '0;
        bus_ack = 1'b0;
        for (int i = 0; i < 16; i++) regs[i] = 32'h100 * i;
        repeat (2) step();
        total++;
        if (outbound_instruction !== NOP_INSTRUCTION || bus_request !== 1'b0 || bus_write !== 1'b0 ||
            bus_error !== 1'b0 || data_out !== 32'h0 || bus_address !== 32'h0 ||
            bus_data_out !== 32'h0 || bus_cycle_width !== CW_LONG || stall !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got out=%h req=%b wr=%b err=%b dout=%h addr=%h bdo=%h cw=%b stall=%b expected NOP/0/0/0/0/0/0/%b/0",
                     outbound_instruction, bus_request, bus_write, bus_error, data_out,
                     bus_address, bus_data_out, bus_cycle_width, stall, CW_LONG);
        end
        reset = 1'b1;
    endtask

    task automatic test_nonmem_back_to_back();
        logic [31:0] i1, i2;
        i1 = mk(OPCODE_ADD, CW_LONG, 4'd1, 4'd2, 16'h0003);
        i2 = mk(OPCODE_ADD, CW_BYTE, 4'd7, 4'd3, 16'h0009);
        inbound_instruction = i1;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL nonmem_stall got=%b expected=0", stall);
        end
        expq.push_back(i1);
        step();
        inbound_instruction = i2;
        expq.push_back(i2);
        step();
        inbound_instruction = NOP_INSTRUCTION;
        total++;
        if (outbound_instruction !== i2) begin
            bad++;
            $display("FAIL nonmem_latency got=%h expected=%h", outbound_instruction, i2);
        end
        step();
    endtask

    task automatic test_load();
        logic [31:0] ins;
        ins = mk(OPCODE_LOAD, CW_LONG, 4'd0, 4'd0, 16'h0010);
        inbound_instruction = ins;
        #1;
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("FAIL load_issue_stall got=%b expected=1", stall);
        end
        expq.push_back(ins);
        step();
        total++;
        if (bus_request !== 1'b1 || bus_write !== 1'b0 || bus_address !== 32'h10 ||
            bus_cycle_width !== CW_LONG || outbound_instruction !== NOP_INSTRUCTION) begin
            bad++;
            $display("FAIL load_bus got req=%b wr=%b addr=%h cw=%b out=%h expected 1/0/00000010/%b/NOP",
                     bus_request, bus_write, bus_address, bus_cycle_width, outbound_instruction, CW_LONG);
        end
        bus_ack = 1'b1;
        bus_data_in = 32'hDEADBEEF;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL load_ack_stall got=%b expected=0", stall);
        end
        step();
        bus_ack = 1'b0;
        bus_data_in = '0;
        inbound_instruction = NOP_INSTRUCTION;
        total++;
        if (data_out !== 32'hDEADBEEF || bus_request !== 1'b0) begin
            bad++;
            $display("FAIL load_data got dout=%h req=%b expected deadbeef/0", data_out, bus_request);
        end
        step();
    endtask

    task automatic test_loadr_wait();
        logic [31:0] ins;
        regs[3] = 32'h0000_1000;
        ins = mk(OPCODE_LOADR, CW_WORD, 4'd0, 4'd3, 16'hFFFC);
        inbound_instruction = ins;
        expq.push_back(ins);
        step();
        total++;
        if (bus_address !== 32'h0000_0FFC || bus_cycle_width !== CW_WORD) begin
            bad++;
            $display("FAIL loadr_addr got addr=%h cw=%b expected 00000ffc/%b", bus_address, bus_cycle_width, CW_WORD);
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (stall !== 1'b1 || bus_request !== 1'b1) begin
                bad++;
                $display("FAIL loadr_wait%0d got stall=%b req=%b expected 1/1", k, stall, bus_request);
            end
            step();
            total++;
            if (outbound_instruction !== NOP_INSTRUCTION) begin
                bad++;
                $display("FAIL loadr_bubble%0d got=%h expected=NOP", k, outbound_instruction);
            end
        end
        bus_ack = 1'b1;
        bus_data_in = 32'h1234_5678;
        step();
        bus_ack = 1'b0;
        inbound_instruction = NOP_INSTRUCTION;
        total++;
        if (data_out !== 32'h1234_5678 || outbound_instruction !== ins) begin
            bad++;
            $display("FAIL loadr_done got dout=%h out=%h expected 12345678/%h", data_out, outbound_instruction, ins);
        end
        step();
    endtask

    task automatic test_hazard();
        logic [31:0] ins, ins2;
        regs[3] = 32'h0000_2000;
        regs[5] = 32'hCAFE_F00D;
        ins = mk(OPCODE_STORER, CW_BYTE, 4'd5, 4'd3, 16'h0004);
        inbound_instruction = ins;
        s2_writing = 1'b1;
        s2_write_index = 4'd3;
        #1;
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("FAIL hazard_stall got=%b expected=1", stall);
        end
        step();
        total++;
        if (outbound_instruction !== NOP_INSTRUCTION || bus_request !== 1'b0) begin
            bad++;
            $display("FAIL hazard_bubble got out=%h req=%b expected NOP/0", outbound_instruction, bus_request);
        end
        s2_writing = 1'b0;
        regs[3] = 32'h0000_3000;
        expq.push_back(ins);
        step();
        total++;
        if (bus_request !== 1'b1 || bus_write !== 1'b1 || bus_address !== 32'h0000_3004 ||
            bus_data_out !== 32'hCAFE_F00D || bus_cycle_width !== CW_BYTE) begin
            bad++;
            $display("FAIL storer_bus got req=%b wr=%b addr=%h bdo=%h cw=%b expected 1/1/00003004/cafef00d/%b",
                     bus_request, bus_write, bus_address, bus_data_out, bus_cycle_width, CW_BYTE);
        end
        bus_ack = 1'b1;
        bus_data_in = 32'h5555_AAAA;
        step();
        bus_ack = 1'b0;
        total++;
        if (data_out !== 32'h1234_5678 || bus_request !== 1'b0) begin
            bad++;
            $display("FAIL store_keeps_data got dout=%h req=%b expected 12345678/0", data_out, bus_request);
        end
        // STORE depends on B only: a write to its B register stalls, a write to A does not.
        ins2 = mk(OPCODE_STORE, CW_LONG, 4'd5, 4'd3, 16'h8000);
        inbound_instruction = ins2;
        s2_writing = 1'b1;
        s2_write_index = 4'd5;
        step();
        total++;
        if (bus_request !== 1'b0) begin
            bad++;
            $display("FAIL store_b_hazard got req=%b expected=0", bus_request);
        end
        s2_write_index = 4'd3;
        expq.push_back(ins2);
        step();
        s2_writing = 1'b0;
        total++;
        if (bus_request !== 1'b1 || bus_address !== 32'hFFFF_8000) begin
            bad++;
            $display("FAIL store_a_no_hazard got req=%b addr=%h expected 1/ffff8000", bus_request, bus_address);
        end
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        inbound_instruction = NOP_INSTRUCTION;
        step();
    endtask

    task automatic test_jump();
        inbound_instruction = mk(OPCODE_STORER, CW_LONG, 4'd5, 4'd3, 16'h0000);
        s2_writing = 1'b1;
        s2_write_index = 4'd3;
        jump = 1'b1;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL jump_stall got=%b expected=0", stall);
        end
        step();
        s2_writing = 1'b0;
        inbound_instruction = mk(OPCODE_STORE, CW_LONG, 4'd1, 4'd0, 16'h0020);
        step();
        jump = 1'b0;
        inbound_instruction = NOP_INSTRUCTION;
        total++;
        if (bus_request !== 1'b0 || outbound_instruction !== NOP_INSTRUCTION) begin
            bad++;
            $display("FAIL jump_squash got req=%b out=%h expected 0/NOP", bus_request, outbound_instruction);
        end
        step();
    endtask

    task automatic test_timeout();
        int waits;
        inbound_instruction = mk(OPCODE_LOAD, CW_LONG, 4'd0, 4'd0, 16'h0040);
        step();
        inbound_instruction = NOP_INSTRUCTION;
        waits = 0;
        while (bus_request === 1'b1 && waits < 20) begin
            step();
            waits++;
        end
        total++;
        if (waits !== 4 || bus_error !== 1'b1 || outbound_instruction !== NOP_INSTRUCTION) begin
            bad++;
            $display("FAIL timeout got waits=%0d err=%b out=%h expected 4/1/NOP", waits, bus_error, outbound_instruction);
        end
        repeat (3) step();
        total++;
        if (bus_error !== 1'b1) begin
            bad++;
            $display("FAIL error_sticky got=%b expected=1", bus_error);
        end
    endtask

    task automatic test_reset_midwait();
        inbound_instruction = mk(OPCODE_LOAD, CW_BYTE, 4'd0, 4'd0, 16'h0044);
        step();
        total++;
        if (bus_request !== 1'b1) begin
            bad++;
            $display("FAIL midwait_issue got req=%b expected=1", bus_request);
        end
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (bus_request !== 1'b0 || bus_error !== 1'b0 || outbound_instruction !== NOP_INSTRUCTION ||
            data_out !== 32'h0 || bus_address !== 32'h0 || bus_cycle_width !== CW_LONG) begin
            bad++;
            $display("FAIL async_reset got req=%b err=%b out=%h dout=%h addr=%h cw=%b expected 0/0/NOP/0/0/%b",
                     bus_request, bus_error, outbound_instruction, data_out, bus_address, bus_cycle_width, CW_LONG);
        end
        inbound_instruction = NOP_INSTRUCTION;
        step();
        reset = 1'b1;
        repeat (2) step();
    endtask

    initial begin
        test_reset();
        test_nonmem_back_to_back();
        test_load();
        test_loadr_wait();
        test_hazard();
        test_jump();
        test_timeout();
        test_reset_midwait();
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d pending expected=0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
